// File: rtl/tcb_lib_arbitrated_multiplexer.sv
// rtl/tcb_lib_arbitrated_multiplexer.sv - fixed-priority N-to-1 TCB arbiter and multiplexer with delayed response routing
//
// Purpose:
//   IFN upstream managers share one downstream subordinate. A combinational
//   fixed-priority arbiter picks one requesting manager per cycle and its
//   request is forwarded downstream. Each response returns DLY cycles after
//   its request transfer and is routed back to the manager that was granted.
//
// Ports:
//   clk_i, rst_ni         clock (rising edge), asynchronous active-low reset
//   sub_vld_i/sub_rdy_o   upstream request handshake, one bit per manager
//   sub_wen_i/adr/ben/wdt upstream request fields, packed per manager
//   sub_rdt_o/sub_err_o   upstream response (read data broadcast, err routed)
//   man_vld_o/man_rdy_i   downstream request handshake
//   man_wen/adr/ben/wdt_o downstream request fields of the granted manager
//   man_rdt_i/man_err_i   downstream response
//   sel_o                 current grant index
module tcb_lib_arbitrated_multiplexer #(
  parameter  int unsigned DLY = 1,
  parameter  int unsigned ADR = 32,
  parameter  int unsigned DAT = 32,
  parameter  int unsigned IFN = 3,
  parameter  int unsigned IFL = $clog2(IFN),
  parameter  int unsigned PRI [IFN-1:0] = '{2, 1, 0},
  localparam int unsigned BEN = DAT/8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [IFN-1:0]     sub_vld_i,
  output logic [IFN-1:0]     sub_rdy_o,
  input  logic [IFN-1:0]     sub_wen_i,
  input  logic [IFN*ADR-1:0] sub_adr_i,
  input  logic [IFN*BEN-1:0] sub_ben_i,
  input  logic [IFN*DAT-1:0] sub_wdt_i,
  output logic [IFN*DAT-1:0] sub_rdt_o,
  output logic [IFN-1:0]     sub_err_o,
  output logic               man_vld_o,
  input  logic               man_rdy_i,
  output logic               man_wen_o,
  output logic [ADR-1:0]     man_adr_o,
  output logic [BEN-1:0]     man_ben_o,
  output logic [DAT-1:0]     man_wdt_o,
  input  logic [DAT-1:0]     man_rdt_i,
  input  logic               man_err_i,
  output logic [IFL-1:0]     sel_o
);

  logic [IFL-1:0] gnt_sel;
  logic           rsp_vld;
  logic [IFL-1:0] rsp_sel;

  // Strict less-than keeps the lowest index among equal priorities.
  always_comb begin
    logic        found;
    int unsigned best;
    gnt_sel = '0;
    found   = 1'b0;
    best    = 0;
    for (int i = 0; i < IFN; i++) begin
      if (sub_vld_i[i] && (!found || (PRI[i] < best))) begin
        found   = 1'b1;
        best    = PRI[i];
        gnt_sel = IFL'(i);
      end
    end
  end

  assign sel_o     = gnt_sel;
  assign man_vld_o = |sub_vld_i;
  assign man_wen_o = sub_wen_i[gnt_sel];
  assign man_adr_o = sub_adr_i[gnt_sel*ADR +: ADR];
  assign man_ben_o = sub_ben_i[gnt_sel*BEN +: BEN];
  assign man_wdt_o = sub_wdt_i[gnt_sel*DAT +: DAT];

  // The granted index sees ready even when nobody requests (sel defaults to 0);
  // without a request no transfer happens, so this is harmless.
  always_comb begin
    sub_rdy_o          = '0;
    sub_rdy_o[gnt_sel] = man_rdy_i;
  end

  generate
    if (DLY == 0) begin : g_nodly
      assign rsp_vld = man_vld_o & man_rdy_i;
      assign rsp_sel = gnt_sel;
    end else begin : g_dly
      // Stage k holds {transfer happened, grant index} from k+1 cycles ago.
      logic [DLY-1:0] vld_q;
      logic [IFL-1:0] sel_q [DLY];
      logic           vld_d;

      assign vld_d = man_vld_o & man_rdy_i;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          vld_q <= '0;
          for (int k = 0; k < DLY; k++) begin
            sel_q[k] <= '0;
          end
        end else begin
          vld_q[0] <= vld_d;
          sel_q[0] <= gnt_sel;
          for (int k = 1; k < DLY; k++) begin
            vld_q[k] <= vld_q[k-1];
            sel_q[k] <= sel_q[k-1];
          end
        end
      end

      assign rsp_vld = vld_q[DLY-1];
      assign rsp_sel = sel_q[DLY-1];
    end
  endgenerate

  // Read data goes to everyone; only the owner of the response samples it.
  assign sub_rdt_o = {IFN{man_rdt_i}};

  always_comb begin
    sub_err_o = '0;
    if (rsp_vld) begin
      sub_err_o[rsp_sel] = man_err_i;
    end
  end

endmodule

// File: tb/tb_tcb_lib_arbitrated_multiplexer.sv
// tb/tb_tcb_lib_arbitrated_multiplexer.sv - self-checking bench for tcb_lib_arbitrated_multiplexer
module tb_tcb_lib_arbitrated_multiplexer;
  localparam int IFN = 3;
  localparam int ADR = 32;
  localparam int DAT = 32;
  localparam int BEN = 4;
  localparam int DLY = 1;
  localparam logic [31:0] ERR_ADR = 32'h0000_000C;
  localparam int TB_PRI [IFN] = '{0, 1, 2};

  typedef struct {
    logic        wen;
    logic [31:0] adr;
    logic [3:0]  ben;
    logic [31:0] wdt;
  } req_t;

  typedef struct {
    logic        v;
    int          mgr;
    logic        wen;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  typedef struct {
    logic [2:0] vld;
    logic       rdy;
    int         exp_sel;
    logic       exp_mv;
    logic [2:0] exp_rdy;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [IFN-1:0]     sub_vld = '0;
  logic [IFN-1:0]     sub_rdy;
  logic [IFN-1:0]     sub_wen = '0;
  logic [IFN*ADR-1:0] sub_adr = '0;
  logic [IFN*BEN-1:0] sub_ben = '0;
  logic [IFN*DAT-1:0] sub_wdt = '0;
  logic [IFN*DAT-1:0] sub_rdt;
  logic [IFN-1:0]     sub_err;
  logic               man_vld;
  logic               man_rdy = 1'b0;
  logic               man_wen;
  logic [ADR-1:0]     man_adr;
  logic [BEN-1:0]     man_ben;
  logic [DAT-1:0]     man_wdt;
  logic [DAT-1:0]     man_rdt;
  logic               man_err;
  logic [1:0]         sel;

  always #5 clk = ~clk;

  tcb_lib_arbitrated_multiplexer #(
    .DLY(DLY), .ADR(ADR), .DAT(DAT), .IFN(IFN), .IFL(2), .PRI('{2, 1, 0})
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .sub_vld_i(sub_vld), .sub_rdy_o(sub_rdy), .sub_wen_i(sub_wen),
    .sub_adr_i(sub_adr), .sub_ben_i(sub_ben), .sub_wdt_i(sub_wdt),
    .sub_rdt_o(sub_rdt), .sub_err_o(sub_err),
    .man_vld_o(man_vld), .man_rdy_i(man_rdy), .man_wen_o(man_wen),
    .man_adr_o(man_adr), .man_ben_o(man_ben), .man_wdt_o(man_wdt),
    .man_rdt_i(man_rdt), .man_err_i(man_err), .sel_o(sel)
  );

  // Downstream memory: one-cycle response, err for reads of ERR_ADR.
  logic        env_clr = 1'b1;
  logic        err_hold = 1'b0;
  logic [31:0] env_rdt;
  logic        env_err;
  logic [31:0] smem [256];

  function automatic int midx(logic [31:0] a);
    return int'({a[17:16], a[7:2]});
  endfunction

  always @(posedge clk) begin
    if (env_clr) begin
      for (int k = 0; k < 256; k++) smem[k] <= '0;
      env_rdt <= '0;
      env_err <= 1'b0;
    end else if (man_vld && man_rdy) begin
      if (man_wen)
        for (int b = 0; b < BEN; b++)
          if (man_ben[b]) smem[midx(man_adr)][8*b +: 8] <= man_wdt[8*b +: 8];
      env_rdt <= smem[midx(man_adr)];
      env_err <= !man_wen && (man_adr == ERR_ADR);
    end else begin
      env_rdt <= 32'hBAD0_BAD0;
      env_err <= 1'b0;
    end
  end

  assign man_rdt = env_rdt;
  assign man_err = env_err | err_hold;

  // Reference model state
  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [31:0] rmem [256];
  req_t        mq [IFN][$];
  rsp_t        rq [$];
  int          grant_log [$];
  int          grant_cyc [$];
  logic [31:0] rd_log [IFN][$];
  int          err_cnt [IFN];
  logic        rnd_mode = 1'b0;
  logic        rdy_val = 1'b1;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic req_t mk(logic wen, logic [31:0] adr, logic [3:0] ben, logic [31:0] wdt);
    req_t r;
    r.wen = wen; r.adr = adr; r.ben = ben; r.wdt = wdt;
    return r;
  endfunction

  // Walk priority levels from most to least urgent; first requester at a level wins.
  function automatic int winner(logic [IFN-1:0] v);
    for (int p = 0; p < IFN; p++)
      for (int i = 0; i < IFN; i++)
        if (v[i] && TB_PRI[i] == p) return i;
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < IFN; i++) begin
      if (rnd_mode && mq[i].size() == 0 && $urandom_range(1, 0) == 1)
        mq[i].push_back(mk(1'($urandom_range(1, 0)), 32'($urandom_range(15, 0)) << 2,
                           4'($urandom_range(15, 1)), $urandom));
      if (mq[i].size() > 0) begin
        sub_vld[i]           = 1'b1;
        sub_wen[i]           = mq[i][0].wen;
        sub_adr[i*ADR +: ADR] = mq[i][0].adr;
        sub_ben[i*BEN +: BEN] = mq[i][0].ben;
        sub_wdt[i*DAT +: DAT] = mq[i][0].wdt;
      end else begin
        sub_vld[i]           = 1'b0;
        sub_wen[i]           = 1'($urandom_range(1, 0));
        sub_adr[i*ADR +: ADR] = $urandom;
        sub_ben[i*BEN +: BEN] = 4'($urandom_range(15, 0));
        sub_wdt[i*DAT +: DAT] = $urandom;
      end
    end
    man_rdy = rnd_mode ? ($urandom_range(3, 0) != 0) : rdy_val;
  endtask

  task automatic check_cycle();
    rsp_t        r, n;
    int          w, ws;
    logic [2:0]  exp_err;
    req_t        q;
    r.v = 1'b0; r.mgr = 0; r.wen = 1'b0; r.data = '0; r.err = 1'b0;
    n = r;
    if (rq.size() == DLY) r = rq.pop_front();
    exp_err = '0;
    if (r.v && r.err) exp_err[r.mgr] = 1'b1;
    chk("sub_err", sub_err, exp_err);
    for (int i = 0; i < IFN; i++) if (sub_err[i]) err_cnt[i]++;
    chk("sub_rdt_bcast", sub_rdt, {IFN{man_rdt}});
    if (r.v && !r.wen) begin
      chk("rd_data", sub_rdt[r.mgr*DAT +: DAT], r.data);
      rd_log[r.mgr].push_back(sub_rdt[r.mgr*DAT +: DAT]);
    end
    w  = winner(sub_vld);
    ws = (w < 0) ? 0 : w;
    chk("sel", sel, ws);
    chk("man_vld", man_vld, w >= 0);
    chk("sub_rdy", sub_rdy, man_rdy ? (1 << ws) : 0);
    if (w >= 0) begin
      chk("man_wen", man_wen, mq[w][0].wen);
      chk("man_adr", man_adr, mq[w][0].adr);
      chk("man_ben", man_ben, mq[w][0].ben);
      chk("man_wdt", man_wdt, mq[w][0].wdt);
      if (man_rdy) begin
        q = mq[w].pop_front();
        grant_log.push_back(w);
        grant_cyc.push_back(cyc);
        if (q.wen)
          for (int b = 0; b < BEN; b++)
            if (q.ben[b]) rmem[midx(q.adr)][8*b +: 8] = q.wdt[8*b +: 8];
        n.v = 1'b1; n.mgr = w; n.wen = q.wen;
        n.data = rmem[midx(q.adr)];
        n.err = !q.wen && (q.adr == ERR_ADR);
      end
    end
    rq.push_back(n);
  endtask

  task automatic step();
    drive();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic int pending();
    return mq[0].size() + mq[1].size() + mq[2].size();
  endfunction

  task automatic run_until_idle(int limit);
    int c = 0;
    while (pending() > 0 && c < limit) begin
      step();
      c++;
    end
    chk("drain", pending(), 0);
    repeat (DLY + 1) step();
  endtask

  vec_t vt [11];

  initial begin
    vt[0]  = '{3'b000, 1'b1, 0, 1'b0, 3'b001};
    vt[1]  = '{3'b001, 1'b1, 0, 1'b1, 3'b001};
    vt[2]  = '{3'b010, 1'b1, 1, 1'b1, 3'b010};
    vt[3]  = '{3'b100, 1'b1, 2, 1'b1, 3'b100};
    vt[4]  = '{3'b110, 1'b1, 1, 1'b1, 3'b010};
    vt[5]  = '{3'b101, 1'b1, 0, 1'b1, 3'b001};
    vt[6]  = '{3'b111, 1'b1, 0, 1'b1, 3'b001};
    vt[7]  = '{3'b111, 1'b0, 0, 1'b1, 3'b000};
    vt[8]  = '{3'b110, 1'b0, 1, 1'b1, 3'b000};
    vt[9]  = '{3'b100, 1'b0, 2, 1'b1, 3'b000};
    vt[10] = '{3'b000, 1'b0, 0, 1'b0, 3'b000};
    for (int k = 0; k < 256; k++) rmem[k] = '0;
    for (int i = 0; i < IFN; i++) err_cnt[i] = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sub_err", sub_err, 3'b000);
    sub_vld = 3'b110;
    #1;
    chk("rst_sel", sel, 1);
    chk("rst_man_vld", man_vld, 1'b1);
    sub_vld = '0;
    env_clr = 1'b0;
    rst_n   = 1'b1;
    @(posedge clk);
    #1;

    // Combinational arbitration table
    foreach (vt[t]) begin
      sub_vld = vt[t].vld;
      man_rdy = vt[t].rdy;
      sub_wen = '0;
      for (int i = 0; i < IFN; i++) begin
        sub_adr[i*ADR +: ADR] = (32'(i) << 16) | 32'h40;
        sub_ben[i*BEN +: BEN] = 4'hF;
      end
      @(negedge clk);
      chk("tbl_sel", sel, vt[t].exp_sel);
      chk("tbl_man_vld", man_vld, vt[t].exp_mv);
      chk("tbl_sub_rdy", sub_rdy, vt[t].exp_rdy);
      if (vt[t].exp_mv) chk("tbl_man_adr", man_adr, (32'(vt[t].exp_sel) << 16) | 32'h40);
      @(posedge clk);
      #1;
    end
    sub_vld = '0;
    man_rdy = 1'b0;
    @(posedge clk);
    #1;
    rq.delete();

    // Single writes then reads, one manager at a time
    rdy_val = 1'b1;
    for (int i = 0; i < IFN; i++) begin
      rd_log[i].delete();
      mq[i].push_back(mk(1'b1, (32'(i) << 16),          4'hF, 32'h7654_3210));
      mq[i].push_back(mk(1'b1, (32'(i) << 16) + 32'h20, 4'hF, 32'hFEDC_BA98));
      mq[i].push_back(mk(1'b0, (32'(i) << 16),          4'hF, 32'h0));
      mq[i].push_back(mk(1'b0, (32'(i) << 16) + 32'h20, 4'hF, 32'h0));
      run_until_idle(20);
      chk("single_rd_cnt", rd_log[i].size(), 2);
      if (rd_log[i].size() == 2) begin
        chk("single_rd0", rd_log[i][0], 32'h7654_3210);
        chk("single_rd1", rd_log[i][1], 32'hFEDC_BA98);
      end
    end

    // Simultaneous writes: grants 0,1,2 on consecutive cycles
    grant_log.delete(); grant_cyc.delete();
    mq[0].push_back(mk(1'b1, 32'h0, 4'hF, 32'h0302_0100));
    mq[1].push_back(mk(1'b1, 32'h4, 4'hF, 32'h1312_1110));
    mq[2].push_back(mk(1'b1, 32'hC, 4'hF, 32'h2322_2120));
    run_until_idle(10);
    chk("simw_cnt", grant_log.size(), 3);
    if (grant_log.size() == 3) begin
      chk("simw_g0", grant_log[0], 0);
      chk("simw_g1", grant_log[1], 1);
      chk("simw_g2", grant_log[2], 2);
      chk("simw_span", grant_cyc[2] - grant_cyc[0], 2);
    end

    // Simultaneous reads, error only for manager 2
    for (int i = 0; i < IFN; i++) begin rd_log[i].delete(); err_cnt[i] = 0; end
    mq[0].push_back(mk(1'b0, 32'h0, 4'hF, 32'h0));
    mq[1].push_back(mk(1'b0, 32'h4, 4'hF, 32'h0));
    mq[2].push_back(mk(1'b0, 32'hC, 4'hF, 32'h0));
    run_until_idle(10);
    if (rd_log[0].size() > 0) chk("simr_m0", rd_log[0][0], 32'h0302_0100); else chk("simr_m0_cnt", 0, 1);
    if (rd_log[1].size() > 0) chk("simr_m1", rd_log[1][0], 32'h1312_1110); else chk("simr_m1_cnt", 0, 1);
    if (rd_log[2].size() > 0) chk("simr_m2", rd_log[2][0], 32'h2322_2120); else chk("simr_m2_cnt", 0, 1);
    chk("err_m0", err_cnt[0], 0);
    chk("err_m1", err_cnt[1], 0);
    chk("err_m2", err_cnt[2], 1);

    // Backpressure with managers 1 and 2 waiting
    grant_log.delete(); grant_cyc.delete();
    rdy_val = 1'b0;
    mq[1].push_back(mk(1'b0, 32'h4, 4'hF, 32'h0));
    mq[2].push_back(mk(1'b1, 32'h8, 4'hF, 32'hA5A5_5A5A));
    repeat (3) step();
    chk("bp_no_grant", grant_log.size(), 0);
    rdy_val = 1'b1;
    run_until_idle(10);
    if (grant_log.size() > 0) chk("bp_first", grant_log[0], 1); else chk("bp_first_cnt", 0, 1);

    // Reset with a response in flight
    mq[2].push_back(mk(1'b0, ERR_ADR, 4'hF, 32'h0));
    step();
    drive();
    #1;
    chk("inflight_err", sub_err, 3'b100);
    rst_n = 1'b0;
    #1;
    chk("rst_async_err", sub_err, 3'b000);
    err_hold = 1'b1;
    rq.delete();
    @(negedge clk);
    chk("rst_hold_err", sub_err, 3'b000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mq[0].push_back(mk(1'b1, 32'h30, 4'hF, 32'hC0DE_0030));
    step();
    err_hold = 1'b0;
    mq[0].push_back(mk(1'b0, 32'h30, 4'hF, 32'h0));
    run_until_idle(10);

    // Randomized traffic against the model
    rnd_mode = 1'b1;
    repeat (400) step();
    rnd_mode = 1'b0;
    rdy_val  = 1'b1;
    run_until_idle(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/tcb_lib_arbitrated_multiplexer.md
Name: tcb_lib_arbitrated_multiplexer

Overview:
- N-to-1 Tightly Coupled Bus (TCB) interconnect stage: IFN upstream managers share one downstream subordinate.
- A fixed-priority arbiter picks one requesting manager per cycle. A multiplexer forwards its request downstream.
- Responses return to the manager that was granted DLY cycles earlier.
- Sits between CPU/DMA bus managers and a shared memory or peripheral port.

Parameters:
- DLY, 1: response delay in cycles from request transfer to response (0 allowed).
- ADR, 32: address width.
- DAT, 32: data width; BEN=DAT/8 byte enables.
- IFN, 3: number of upstream interfaces (>=2).
- IFL, $clog2(IFN): select width.
- PRI, {2,1,0} (PRI[i] for interface i): priority per interface; lower number wins; PRI[0]=0 is highest.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- sub_vld  in  IFN  upstream request valid.
- sub_rdy  out  IFN  upstream ready.
- sub_wen  in  IFN  write enable (0=read).
- sub_adr  in  IFN*ADR  address.
- sub_ben  in  IFN*BEN  byte enables.
- sub_wdt  in  IFN*DAT  write data.
- sub_rdt  out  IFN*DAT  read data.
- sub_err  out  IFN  error response.
- man_vld  out  1  downstream valid.
- man_rdy  in  1  downstream ready.
- man_wen  out  1  write enable.
- man_adr  out  ADR  address.
- man_ben  out  BEN  byte enables.
- man_wdt  out  DAT  write data.
- man_rdt  in  DAT  read data.
- man_err  in  1  error response.
- sel  out  IFL  current grant index (observability).

Behaviour:
- Transfer: a transfer occurs on a cycle with vld&rdy at a rising clk edge. Managers hold the request stable until the transfer.
- Arbitration (combinational):
  - sel = index i with sub_vld[i]=1 and minimal PRI[i].
  - Equal PRI values: the lower index wins.
  - No sub_vld: sel=0.
  - The grant may change between cycles while no transfer has taken place; no lock is kept.
- Request mux:
  - man_vld = |sub_vld.
  - man_wen/adr/ben/wdt = fields of interface sel.
- Ready:
  - sub_rdy[i] = man_rdy & (sel==i).
  - Ungranted managers see rdy=0 and keep waiting.
  - Exactly one upstream transfer per downstream transfer.
- Response routing, DLY>0:
  - A shift register of DLY stages holds {valid, sel}.
  - Stage 0 loads {man_vld&man_rdy, sel} every cycle.
  - The response at cycle t+DLY is routed to the stored index.
- Response routing, DLY=0: the response is routed with the current sel, combinationally.
- Response outputs:
  - sub_rdt[i] = man_rdt for all i (broadcast); managers sample it only for their own outstanding transfer.
  - sub_err[i] = man_err & rsp_valid & (rsp_sel==i). Non-target err=0.
- Back-to-back transfers from different managers are allowed every cycle; each response is routed independently.
- Reset (rst=0, asynchronous):
  - Delay line cleared: valid=0, sel=0.
  - All sub_err=0.
  - Combinational outputs follow their inputs.
- Reset mid-operation discards in-flight responses.
- After reset release, the first transfer is accepted in the first cycle.
- No internal buffering: throughput equals the downstream throughput.
- Combinational path from sub_vld through sel to man_* and sub_rdy is permitted.

Test Plan:
- Single writes, one manager at a time: each manager i writes 0x76543210 to (i<<16)+0x00 and 0xFEDCBA98 to (i<<16)+0x20, then reads both back with ben=4'b1111.
  -> Downstream sees identical adr/wdt/ben; reads return 0x76543210 and 0xFEDCBA98; err=0.
- Simultaneous writes: managers 0, 1, 2 write 0x03020100@0x0, 0x13121110@0x4, 0x23222120@0xC in the same cycle, man_rdy=1.
  -> Transfers occur in order 0, 1, 2 on consecutive cycles; sel=0, 1, 2.
- Simultaneous reads of the same addresses.
  -> Manager 0 gets 0x03020100, manager 1 gets 0x13121110, manager 2 gets 0x23222120, each DLY cycles after its own transfer.
- Backpressure: man_rdy=0 for 3 cycles with managers 1 and 2 valid.
  -> No sub_rdy asserted, sel=1 throughout; when rdy rises, manager 1 completes first.
- Error routing: the subordinate returns err=1 for manager 2's read only.
  -> Only sub_err[2]=1; managers 0 and 1 see err=0.
- Asynchronous reset asserted with a response in flight.
  -> All sub_err=0 immediately; no stale response is routed after release.
